instrmemory: RTL

INSTRMEMORY -- requirements
Module: instrmemory

---
 rtl/instrmemory.sv | 103 ++++++++++
 1 files changed

// File: rtl/instrmemory.sv
// Instruction memory with program-load port and fixed-latency fetch handshake.
// Optional macro INSTRMEM_WRAP_EN: out-of-range fetches wrap instead of faulting.
module instrmemory #(
  parameter int DEPTH_LOG2 = 10,
  parameter int LATENCY    = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic [31:0]           req_addr,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [31:0]           rsp_instr,
  output logic                  rsp_err,
  input  logic                  load_en,
  input  logic [DEPTH_LOG2-1:0] load_addr,
  input  logic [31:0]           load_data
);

  // state | meaning
  // IDLE  | ready for a fetch (unless a load is in progress)
  // WAIT  | fetch latched, counting out the remaining latency
  // RESP  | response presented, holding until rsp_ready
  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  localparam int CW = 3;
`ifdef INSTRMEM_WRAP_EN
  localparam bit WRAP = 1'b1;
`else
  localparam bit WRAP = 1'b0;
`endif

  state_t                  state, state_nxt;
  logic [CW-1:0]           cnt, cnt_nxt;
  logic [31:0]             mem [0:(1<<DEPTH_LOG2)-1];
  logic [DEPTH_LOG2-1:0]   word_idx;
  logic                    misaligned, out_of_range, fault, accept;

  assign word_idx     = req_addr[DEPTH_LOG2+1:2];
  assign misaligned   = |req_addr[1:0];
  assign out_of_range = |req_addr[31:DEPTH_LOG2+2];
  assign fault        = misaligned | (out_of_range & ~WRAP);

  assign req_ready = reset && (state == IDLE) && !load_en;
  assign rsp_valid = (state == RESP);
  assign accept    = req_valid && req_ready;

  // Memory contents survive reset; only writes are gated while it is held.
  always_ff @(posedge clk) begin
    if (reset && load_en) mem[load_addr] <= load_data;
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    case (state)
      IDLE: begin
        if (accept) begin
          if (LATENCY == 1) begin
            state_nxt = RESP;
          end else begin
            state_nxt = WAIT;
            cnt_nxt   = CW'(1);
          end
        end
      end
      WAIT: begin
        if (cnt == CW'(LATENCY - 1)) begin
          state_nxt = RESP;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = cnt + CW'(1);
        end
      end
      RESP: begin
        if (rsp_ready) state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
        cnt_nxt   = '0;
      end
    endcase
  end

  // The response is captured at accept, so later loads cannot disturb it.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state     <= IDLE;
      cnt       <= '0;
      rsp_instr <= '0;
      rsp_err   <= 1'b0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      if (accept) begin
        rsp_instr <= fault ? 32'h0 : mem[word_idx];
        rsp_err   <= fault;
      end
    end
  end

endmodule
